// File: rtl/fm_modulate.sv
// FM modulator on AXI-Stream: audio samples steer a phase accumulator and
// each beat emits {phase[31:16], amplitude} through a 2-stage stall-aware pipeline.
module fm_modulate #(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter bit          RESET_PHASE_ON_LAST    = 1'b0
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  m00_axis_tready,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  input  logic [31:0]                           carrier_inc,
  input  logic [15:0]                           dev_gain,
  input  logic [15:0]                           amplitude
);

  localparam int unsigned SB = C_S00_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned MB = C_M00_AXIS_TDATA_WIDTH / 8;

  logic                              en;
  logic                              accept;

  logic                              s1_valid_q, s1_valid_d;
  logic [31:0]                       s1_prod_q,  s1_prod_d;
  logic [31:0]                       s1_inc_q,   s1_inc_d;
  logic [15:0]                       s1_amp_q,   s1_amp_d;
  logic                              s1_last_q,  s1_last_d;
  logic [SB-1:0]                     s1_strb_q,  s1_strb_d;

  logic [31:0]                       phase_q,    phase_d;
  logic                              m_valid_q,  m_valid_d;
  logic                              m_last_q,   m_last_d;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] m_data_q,   m_data_d;
  logic [MB-1:0]                     m_strb_q,   m_strb_d;

  logic signed [32:0]                samp_ext;
  logic signed [32:0]                gain_ext;
  logic signed [32:0]                prod_full;
  logic [31:0]                       phase_sum;
  logic [SB+MB-1:0]                  strb_ext;
  logic                              unused_bits;

  // Whole pipeline advances together; input is accepted whenever the output slot frees.
  assign en              = ~m_valid_q | m00_axis_tready;
  assign accept          = s00_axis_tvalid & en;
  assign s00_axis_tready = en;

  // |sample * gain| < 2^31, so the low 32 bits hold the exact signed product.
  assign samp_ext  = $signed({{17{s00_axis_tdata[15]}}, s00_axis_tdata[15:0]});
  assign gain_ext  = $signed({17'b0, dev_gain});
  assign prod_full = samp_ext * gain_ext;

  assign phase_sum = phase_q + s1_inc_q + s1_prod_q;
  assign strb_ext  = {{MB{1'b0}}, s1_strb_q};

  assign unused_bits = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:16], prod_full[32]};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_inc_d   = s1_inc_q;
    s1_amp_d   = s1_amp_q;
    s1_last_d  = s1_last_q;
    s1_strb_d  = s1_strb_q;
    if (en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_prod_d = prod_full[31:0];
        s1_inc_d  = carrier_inc;
        s1_amp_d  = amplitude;
        s1_last_d = s00_axis_tlast;
        s1_strb_d = s00_axis_tstrb;
      end
    end
  end

  always_comb begin
    phase_d   = phase_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    m_strb_d  = m_strb_q;
    if (en) begin
      if (s1_valid_q) begin
        m_valid_d       = 1'b1;
        m_last_d        = s1_last_q;
        m_strb_d        = strb_ext[MB-1:0];
        m_data_d        = '0;
        m_data_d[31:0]  = {phase_sum[31:16], s1_amp_q};
        // The tlast beat still reports its accumulated phase; only the stored value restarts.
        phase_d         = (RESET_PHASE_ON_LAST && s1_last_q) ? '0 : phase_sum;
      end else begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_inc_q   <= '0;
      s1_amp_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_strb_q  <= '0;
      phase_q    <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      m_strb_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_inc_q   <= s1_inc_d;
      s1_amp_q   <= s1_amp_d;
      s1_last_q  <= s1_last_d;
      s1_strb_q  <= s1_strb_d;
      phase_q    <= phase_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
      m_strb_q   <= m_strb_d;
    end
  end

  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tlast  = m_last_q;
  assign m00_axis_tdata  = m_data_q;
  assign m00_axis_tstrb  = m_strb_q;

endmodule

// File: doc/fm_modulate.md
FM_MODULATE -- requirements
Module: fm_modulate

Interface
REQ-001 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 32: input stream width; only bits [15:0] are used.
REQ-002 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32: output stream width.
REQ-003 SHALL have parameter RESET_PHASE_ON_LAST, default 0: when 1, the phase accumulator clears after each tlast beat.
REQ-004 s00_axis_aclk  input  1  the single clock; all logic on its rising edge.
REQ-005 s00_axis_aresetn  input  1  reset; asynchronous, active-low.
REQ-006 s00_axis_tvalid, s00_axis_tlast  input  1 each  input beat valid and end of packet.
REQ-007 s00_axis_tdata  input  C_S00_AXIS_TDATA_WIDTH  [15:0] is a signed audio sample; [31:16] is ignored.
REQ-008 s00_axis_tstrb  input  C_S00_AXIS_TDATA_WIDTH/8  byte strobes, carried with the beat.
REQ-009 s00_axis_tready  output  1  input accept.
REQ-010 m00_axis_tready  input  1  downstream accept.
REQ-011 m00_axis_tvalid, m00_axis_tlast  output  1 each  output beat valid and end of packet.
REQ-012 m00_axis_tdata  output  C_M00_AXIS_TDATA_WIDTH  [31:16] is the angle (phase[31:16]); [15:0] is the magnitude (unsigned).
REQ-013 m00_axis_tstrb  output  C_M00_AXIS_TDATA_WIDTH/8  strobes of the beat.
REQ-014 carrier_inc  input  32  unsigned carrier phase increment per beat.
REQ-015 dev_gain  input  16  unsigned frequency deviation gain.
REQ-016 amplitude  input  16  magnitude placed in output [15:0].

Function
REQ-017 SHALL be a 2-stage pipeline: S1 registers the product and metadata; S2 holds the phase accumulator and the output register.
REQ-018 Global advance enable en = ~m00_axis_tvalid | m00_axis_tready; s00_axis_tready SHALL equal en, combinationally.
REQ-019 A beat is accepted when s00_axis_tvalid & s00_axis_tready.
- On acceptance, S1 SHALL capture product = signed(tdata[15:0]) * signed({1'b0,dev_gain}) as a 32-bit signed value.
- S1 SHALL also capture carrier_inc, amplitude, tlast and tstrb.
- S1 valid SHALL be set on acceptance and cleared when en is high with no acceptance.
REQ-020 The configuration inputs SHALL be sampled only at acceptance; later changes SHALL NOT affect beats already in flight.
REQ-021 When en is high and S1 is valid, S2 SHALL compute phase <= phase + carrier_inc + product, modulo 2^32.
- Wrap-around SHALL be silent, with no saturation.
- Output tdata SHALL be {new_phase[31:16], amplitude}; tlast and tstrb SHALL be copied from S1; m00_axis_tvalid SHALL be set.
REQ-022 When en is high and S1 is invalid, m00_axis_tvalid SHALL clear and phase SHALL hold.
REQ-023 Latency SHALL be 2 cycles from acceptance to m00_axis_tvalid when unstalled; throughput SHALL be 1 beat per cycle.
REQ-024 While m00_axis_tvalid=1 and m00_axis_tready=0, all of the following SHALL hold stable:
- the output registers;
- S1;
- phase;
- s00_axis_tready, held at 0.
REQ-025 Beats SHALL never be dropped, duplicated or reordered.
REQ-026 With RESET_PHASE_ON_LAST=1, the tlast beat's output SHALL use the normally accumulated phase.
- The stored phase SHALL then become 0, so the next beat's phase = carrier_inc + product.
- With RESET_PHASE_ON_LAST=0, tlast SHALL only be forwarded.
REQ-027 Simultaneous output-consume and input-accept in the same cycle SHALL both take effect, giving no bubble.

Reset
REQ-028 When s00_axis_aresetn=0, the block SHALL asynchronously clear all of the following: phase, S1 valid, m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata, m00_axis_tstrb.
REQ-029 s00_axis_tready SHALL follow REQ-018 and therefore read 1 during reset.
REQ-030 Reset asserted mid-stream SHALL discard every in-flight beat.
REQ-031 After release, the first output SHALL be computed from phase 0.

Verification
REQ-032 Carrier: carrier_inc=0x01000000, dev_gain=0, amplitude=0x7FFF, 4 beats -> tdata 0x01007FFF, 0x02007FFF, 0x03007FFF, 0x04007FFF; first tvalid 2 cycles after first accept.
REQ-033 Deviation: carrier_inc=0, dev_gain=0x0100.
- Samples +0x0100 ×2 -> angles 0x0001, 0x0002.
- Then samples 0xFF00 (−256) ×3 -> angles 0x0001, 0x0000, 0xFFFF.
REQ-034 Wrap: carrier_inc=0x80000000, dev_gain=0, 3 beats -> angles 0x8000, 0x0000, 0x8000.
REQ-035 Backpressure: stream 6 beats with m00_axis_tready held 0 for cycles 3-8 -> s00_axis_tready=0 while stalled; outputs match the unstalled sequence exactly; tdata stable during the stall.
REQ-036 Packet reset: RESET_PHASE_ON_LAST=1, carrier_inc=0x01000000, dev_gain=0.
- A packet of 3 beats (tlast on the 3rd) followed by 2 beats -> angles 0x0100, 0x0200, 0x0300 (tlast=1), 0x0100, 0x0200.
REQ-037 Reset mid-stream: assert aresetn=0 with 2 beats in flight, then release and send 1 beat with carrier_inc=0x00010000 -> m00_axis_tvalid=0 during reset; first output angle 0x0001.
